// File: rtl/word_setter.sv
`default_nettype none
// ============================================================================
// Module      : word_setter
// Description : Setter-side front end for the Wordle game. The setter keys in
//               the secret word one letter at a time using the shared
//               switch-code letter table. The word is confirmed and locked,
//               and then exported to the guess checker. The seven-segment
//               digits show the entry and go blank once the word is locked.
// Revision    : 1.0 - initial release
// ============================================================================
module word_setter #(
    parameter int SEG_W     = 7,
    parameter int N_LETTERS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [9:0]                   switch_input,
    input  logic                         enter,
    input  logic                         clear,
    output logic [SEG_W*N_LETTERS-1:0]   secret_word,
    output logic                         word_valid,
    output logic [SEG_W-1:0]             SS1,
    output logic [SEG_W-1:0]             SS2,
    output logic [SEG_W-1:0]             SS3,
    output logic [SEG_W-1:0]             SS4,
    output logic                         err_led,
    output logic [$clog2(N_LETTERS)-1:0] slot_idx
);

    localparam int SLOT_W = $clog2(N_LETTERS);

    // Segments are active-low, so all ones means the digit is dark
    localparam logic [SEG_W-1:0]  C_BLANK     = '1;
    localparam logic [SLOT_W-1:0] C_LAST_SLOT = SLOT_W'(N_LETTERS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ENTRY   = 2'd1;
    localparam logic [1:0] ST_CONFIRM = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              err_q, err_d;
    logic [SEG_W-1:0]  letters_q [N_LETTERS];
    logic [SEG_W-1:0]  letters_d [N_LETTERS];
    logic [SEG_W-1:0]  disp_q    [N_LETTERS];
    logic [SEG_W-1:0]  disp_d    [N_LETTERS];

    logic              sync1_q, sync2_q, sync3_q;
    logic              press;
    logic              dec_valid;
    logic [SEG_W-1:0]  dec_pat;

    // Shared letter table. Columns are bits [9:3], one-hot, MSB first.
    // Rows: 000 = A..G, 001 = H..N, 010 = O..U, 100 = V..Z.
    // Returns {valid, pattern}. Invalid codes decode to all segments lit.
    function automatic logic [SEG_W:0] decode_letter(input logic [9:0] code);
        logic [SEG_W:0] r;
        r = {1'b1, SEG_W'(7'b0000000)};
        case (code)
            10'b1000000_000: r[SEG_W-1:0] = 7'b0001000; // A
            10'b0100000_000: r[SEG_W-1:0] = 7'b1100000; // B
            10'b0010000_000: r[SEG_W-1:0] = 7'b0110001; // C
            10'b0001000_000: r[SEG_W-1:0] = 7'b1000010; // D
            10'b0000100_000: r[SEG_W-1:0] = 7'b0110000; // E
            10'b0000010_000: r[SEG_W-1:0] = 7'b0111000; // F
            10'b0000001_000: r[SEG_W-1:0] = 7'b0100001; // G
            10'b1000000_001: r[SEG_W-1:0] = 7'b1001000; // H
            10'b0100000_001: r[SEG_W-1:0] = 7'b1001111; // I
            10'b0010000_001: r[SEG_W-1:0] = 7'b1000011; // J
            10'b0001000_001: r[SEG_W-1:0] = 7'b0101000; // K
            10'b0000100_001: r[SEG_W-1:0] = 7'b1110001; // L
            10'b0000010_001: r[SEG_W-1:0] = 7'b0101010; // M
            10'b0000001_001: r[SEG_W-1:0] = 7'b1101010; // N
            10'b1000000_010: r[SEG_W-1:0] = 7'b0000001; // O
            10'b0100000_010: r[SEG_W-1:0] = 7'b0011000; // P
            10'b0010000_010: r[SEG_W-1:0] = 7'b0001100; // Q
            10'b0001000_010: r[SEG_W-1:0] = 7'b1111010; // R
            10'b0000100_010: r[SEG_W-1:0] = 7'b0100100; // S
            10'b0000010_010: r[SEG_W-1:0] = 7'b1001110; // T
            10'b0000001_010: r[SEG_W-1:0] = 7'b1000001; // U
            10'b1000000_100: r[SEG_W-1:0] = 7'b1100011; // V
            10'b0100000_100: r[SEG_W-1:0] = 7'b1001001; // W
            10'b0010000_100: r[SEG_W-1:0] = 7'b0110110; // X
            10'b0001000_100: r[SEG_W-1:0] = 7'b1000100; // Y
            10'b0000100_100: r[SEG_W-1:0] = 7'b0010010; // Z
            default:         r = '0;
        endcase
        return r;
    endfunction

    assign {dec_valid, dec_pat} = decode_letter(switch_input);

    // Two-flop synchronizer for the raw pushbutton, plus one delay flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= enter;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Falling edge of the synchronized button gives one single-cycle press.
    // The flops reset to 0, so releasing reset with the button held never fires.
    assign press = sync3_q & ~sync2_q;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. Clear wins over a press in the same cycle.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            case (state_q)
                ST_CONFIRM: state_d = ST_ENTRY;
                ST_LOCKED:  state_d = ST_IDLE;
                default:    state_d = state_q;
            endcase
        end else if (press) begin
            case (state_q)
                ST_IDLE:    state_d = ST_ENTRY;
                ST_ENTRY:   if (dec_valid && (slot_q == C_LAST_SLOT)) state_d = ST_CONFIRM;
                ST_CONFIRM: state_d = ST_LOCKED;
                default:    state_d = state_q;
            endcase
        end
    end

    // Letter store, slot pointer and error flag updates
    always_comb begin
        letters_d = letters_q;
        slot_d    = slot_q;
        err_d     = err_q;
        if (clear) begin
            for (int i = 0; i < N_LETTERS; i++) begin
                letters_d[i] = C_BLANK;
            end
            slot_d = '0;
            err_d  = 1'b0;
        end else if (press) begin
            case (state_q)
                ST_IDLE: slot_d = '0;
                ST_ENTRY: begin
                    if (dec_valid) begin
                        letters_d[slot_q] = dec_pat;
                        err_d             = 1'b0;
                        // The last slot stays put; the state moves to confirmation instead
                        if (slot_q != C_LAST_SLOT) begin
                            slot_d = slot_q + SLOT_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_LETTERS; i++) begin
                letters_q[i] <= C_BLANK;
            end
            slot_q <= '0;
            err_q  <= 1'b0;
        end else begin
            letters_q <= letters_d;
            slot_q    <= slot_d;
            err_q     <= err_d;
        end
    end

    // FSM outputs: word_valid and next display contents
    always_comb begin
        word_valid = (state_q == ST_LOCKED);
        for (int i = 0; i < N_LETTERS; i++) begin
            disp_d[i] = C_BLANK;
        end
        case (state_q)
            ST_ENTRY: begin
                for (int i = 0; i < N_LETTERS; i++) begin
                    if (i < int'(slot_q)) begin
                        disp_d[i] = letters_q[i];
                    end else if (i == int'(slot_q)) begin
                        disp_d[i] = dec_pat;
                    end else begin
                        disp_d[i] = C_BLANK;
                    end
                end
            end
            ST_CONFIRM: disp_d = letters_q;
            default: ;
        endcase
    end

    // Registered digit drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_LETTERS; i++) begin
                disp_q[i] <= C_BLANK;
            end
        end else begin
            disp_q <= disp_d;
        end
    end

    // First letter lands in the most significant field of the exported word
    for (genvar g = 0; g < N_LETTERS; g++) begin : g_pack
        assign secret_word[SEG_W*(N_LETTERS-g)-1 -: SEG_W] = letters_q[g];
    end

    assign SS1      = disp_q[0];
    assign SS2      = disp_q[1];
    assign SS3      = disp_q[2];
    assign SS4      = disp_q[3];
    assign err_led  = err_q;
    assign slot_idx = slot_q;

endmodule
`default_nettype wire

// File: tb/tb_word_setter.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_setter
// Description : Self-checking bench for word_setter with a queue-based model
//               of the word entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_setter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  switch_input;
    logic        enter;
    logic        clear;
    logic [27:0] secret_word;
    logic        word_valid;
    logic [6:0]  SS1, SS2, SS3, SS4;
    logic        err_led;
    logic [1:0]  slot_idx;

    word_setter dut (
        .clk          (clk),
        .reset        (reset),
        .switch_input (switch_input),
        .enter        (enter),
        .clear        (clear),
        .secret_word  (secret_word),
        .word_valid   (word_valid),
        .SS1          (SS1),
        .SS2          (SS2),
        .SS3          (SS3),
        .SS4          (SS4),
        .err_led      (err_led),
        .slot_idx     (slot_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase name, entered letters, error flag
    localparam int P_IDLE = 0, P_ENTRY = 1, P_CONFIRM = 2, P_LOCKED = 3;
    int         m_phase;
    logic [6:0] m_word [$];
    logic       m_err;

    logic [9:0] known_codes [6];
    logic [6:0] known_pats  [6];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit code_is_valid(input logic [9:0] c);
        logic [6:0] col;
        logic [2:0] row;
        col = c[9:3];
        row = c[2:0];
        if ($countones(col) != 1) return 1'b0;
        if (!(row == 3'b000 || row == 3'b001 || row == 3'b010 || row == 3'b100)) return 1'b0;
        if (row == 3'b100 && (col[1] || col[0])) return 1'b0;
        return 1'b1;
    endfunction

    // Pattern of a code the bench knows; invalid codes light every segment
    function automatic logic [6:0] pat_of(input logic [9:0] c);
        for (int i = 0; i < 6; i++) begin
            if (known_codes[i] == c) return known_pats[i];
        end
        return 7'b0000000;
    endfunction

    function automatic logic [9:0] pick_code();
        logic [9:0] c;
        if ($urandom_range(9, 0) < 6) return known_codes[$urandom_range(5, 0)];
        c = 10'($urandom);
        while (code_is_valid(c)) c = 10'($urandom);
        return c;
    endfunction

    task automatic model_press(input logic [9:0] c);
        case (m_phase)
            P_IDLE: m_phase = P_ENTRY;
            P_ENTRY: begin
                if (code_is_valid(c)) begin
                    m_word.push_back(pat_of(c));
                    m_err = 1'b0;
                    if (m_word.size() == 4) m_phase = P_CONFIRM;
                end else begin
                    m_err = 1'b1;
                end
            end
            P_CONFIRM: m_phase = P_LOCKED;
            default: ;
        endcase
    endtask

    task automatic model_clear();
        m_word.delete();
        m_err = 1'b0;
        if (m_phase == P_LOCKED) m_phase = P_IDLE;
        else if (m_phase == P_CONFIRM) m_phase = P_ENTRY;
    endtask

    task automatic check_all(input string tag);
        logic [27:0] exp_sw;
        logic [6:0]  exp_ss [4];
        int          n;
        n = m_word.size();
        for (int i = 0; i < 4; i++) begin
            exp_sw[27-7*i -: 7] = (i < n) ? m_word[i] : 7'h7F;
            exp_ss[i] = 7'h7F;
            if (m_phase == P_CONFIRM) exp_ss[i] = m_word[i];
            else if (m_phase == P_ENTRY) begin
                if (i < n) exp_ss[i] = m_word[i];
                else if (i == n) exp_ss[i] = pat_of(switch_input);
            end
        end
        check_val({tag, ".secret"}, 32'(secret_word), 32'(exp_sw));
        check_val({tag, ".valid"},  32'(word_valid), 32'(m_phase == P_LOCKED));
        check_val({tag, ".err"},    32'(err_led), 32'(m_err));
        check_val({tag, ".slot"},   32'(slot_idx),
                  32'((m_phase == P_ENTRY) ? n : (m_phase == P_IDLE) ? 0 : 3));
        check_val({tag, ".SS1"}, 32'(SS1), 32'(exp_ss[0]));
        check_val({tag, ".SS2"}, 32'(SS2), 32'(exp_ss[1]));
        check_val({tag, ".SS3"}, 32'(SS3), 32'(exp_ss[2]));
        check_val({tag, ".SS4"}, 32'(SS4), 32'(exp_ss[3]));
    endtask

    task automatic do_press(input logic [9:0] c, input int hold);
        @(negedge clk);
        switch_input = c;
        enter = 1'b0;
        repeat (hold) @(negedge clk);
        enter = 1'b1;
        repeat (4) @(negedge clk);
        model_press(c);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
    endtask

    // Clear is raised while the press pulse is live, so both hit the same edge
    task automatic press_with_clear(input logic [9:0] c);
        @(negedge clk);
        switch_input = c;
        enter = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        enter = 1'b1;
        repeat (4) @(negedge clk);
        model_clear();
    endtask

    initial begin
        logic [1:0] slot_before;
        known_codes = '{10'b1000000000, 10'b0100000000, 10'b0100000001,
                        10'b0000010010, 10'b0000100010, 10'b0100000100};
        known_pats  = '{7'b0001000, 7'b1100000, 7'b1001111,
                        7'b1001110, 7'b0100100, 7'b1001001};
        m_phase = P_IDLE;
        m_err   = 1'b0;
        reset = 1'b1; enter = 1'b1; clear = 1'b0; switch_input = 10'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_all("reset");

        // Word BITS, confirm and lock
        do_press(known_codes[1], 4);
        check_all("idle_to_entry");
        do_press(known_codes[1], 4);   // B
        do_press(known_codes[2], 4);   // I
        do_press(known_codes[3], 4);   // T
        do_press(known_codes[4], 4);   // S
        check_all("confirm_bits");
        do_press(known_codes[0], 4);
        check_all("locked_bits");
        check_val("locked_word", 32'(secret_word), 32'({7'b1100000, 7'b1001111, 7'b1001110, 7'b0100100}));

        // Clear and press together while locked
        press_with_clear(known_codes[0]);
        check_all("locked_clear_press");

        // Invalid code at slot 1, then recovery
        do_press(known_codes[0], 4);
        do_press(known_codes[0], 4);
        do_press(10'b0000000011, 4);
        check_all("invalid_code");
        do_press(known_codes[0], 4);
        check_all("after_invalid");

        // Clear wins over a press in ENTRY
        press_with_clear(known_codes[5]);
        check_all("entry_clear_press");

        // Exact press latency: the action lands on the third rising edge
        @(negedge clk);
        switch_input = known_codes[5];
        slot_before = slot_idx;
        enter = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("latency_2edges", 32'(slot_idx), 32'(slot_before));
        @(negedge clk);
        check_val("latency_3edges", 32'(slot_idx), 32'(slot_before) + 1);
        enter = 1'b1;
        repeat (4) @(negedge clk);
        model_press(known_codes[5]);
        check_all("latency_final");

        // Fill to CONFIRM, then clear back to ENTRY
        do_press(known_codes[4], 4);
        do_press(known_codes[3], 4);
        do_press(known_codes[2], 4);
        check_all("confirm_wsti");
        do_clear();
        check_all("confirm_clear");

        // Long hold gives exactly one press
        do_press(known_codes[2], 50);
        check_all("long_hold");
        do_press(known_codes[1], 4);

        // Asynchronous reset in the middle of a cycle at slot 2
        @(posedge clk);
        #2;
        reset = 1'b1;
        enter = 1'b0;
        #1;
        check_val("async_rst.SS1", 32'(SS1), 32'h7F);
        check_val("async_rst.SS2", 32'(SS2), 32'h7F);
        check_val("async_rst.slot", 32'(slot_idx), 32'd0);
        check_val("async_rst.secret", 32'(secret_word), 32'h0FFFFFFF);
        m_phase = P_IDLE;
        m_word.delete();
        m_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_all("rst_release_low");
        enter = 1'b1;
        repeat (4) @(negedge clk);
        check_all("rst_release_high");

        // Randomized operation mix
        for (int k = 0; k < 80; k++) begin
            int op;
            op = $urandom_range(19, 0);
            if (op < 14)      do_press(pick_code(), 4);
            else if (op < 16) do_clear();
            else if (op < 18) do_press(pick_code(), $urandom_range(30, 5));
            else              press_with_clear(pick_code());
            check_all($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
